tone_period_meter: RTL

TONE_PERIOD_METER -- requirements
Module: tone_period_meter

---
 rtl/tone_period_meter_if.sv | 31 +++
 rtl/tone_period_meter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/tone_period_meter_if.sv
// Tone period meter bus: square-wave input and clear in, measurement results out.
// Latency: none; pure signal grouping.
// Backpressure: none; results are level/pulse outputs with no ready.
interface tone_period_meter_if #(
    parameter int CNT_W = 28
);
    logic             sq_in;
    logic             clr;
    logic [CNT_W-1:0] half_period;
    logic             period_valid;
    logic             locked;
    logic             timeout;

    modport master (
        output sq_in,
        output clr,
        input  half_period,
        input  period_valid,
        input  locked,
        input  timeout
    );

    modport slave (
        input  sq_in,
        input  clr,
        output half_period,
        output period_valid,
        output locked,
        output timeout
    );
endinterface

// File: rtl/tone_period_meter.sv
// Measures the interval between transitions of an asynchronous square wave, flags lock and timeout.
// Latency: edge seen 2 clk after sq_in changes; period_valid/half_period update 1 clk after that.
// Backpressure: none; period_valid is a one-cycle pulse that cannot be stalled.
module tone_period_meter #(
    parameter int CNT_W   = 28,
    parameter int TIMEOUT = 1000000,
    parameter int TOL     = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    tone_period_meter_if.slave     bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TOL_LIM = CNT_W'(TOL);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t           state;
    logic             s1, s2, s3;
    logic             sq_edge;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] meas;
    logic [CNT_W-1:0] diff;
    logic [CNT_W-1:0] hp_q;
    logic             pv_q;
    logic             lock_q;
    logic             to_q;

    // Two-flop synchronizer plus one history flop; clr deliberately does not touch these.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= bus.sq_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign sq_edge = s2 ^ s3;

    // cnt counts cycles since the last edge, so the interval itself is one more than cnt.
    assign meas = cnt + ONE;

    // Absolute difference against the previous measurement, computed without wrap-around.
    always_comb begin
        diff = '0;
        if (meas >= hp_q) begin
            diff = meas - hp_q;
        end else begin
            diff = hp_q - meas;
        end
    end

    // Interval counter and IDLE/ARMED/RUN controller; clr beats edge, edge beats timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            hp_q   <= '0;
            pv_q   <= 1'b0;
            lock_q <= 1'b0;
            to_q   <= 1'b0;
        end else begin
            pv_q <= 1'b0;
            if (bus.clr) begin
                state  <= IDLE;
                cnt    <= '0;
                hp_q   <= '0;
                lock_q <= 1'b0;
                to_q   <= 1'b0;
            end else begin
                if (sq_edge) begin
                    cnt <= '0;
                end else if (cnt != CNT_MAX) begin
                    cnt <= cnt + ONE;
                end

                case (state)
                    IDLE: begin
                        if (sq_edge) begin
                            state <= ARMED;
                        end
                    end
                    ARMED: begin
                        if (sq_edge) begin
                            hp_q   <= meas;
                            pv_q   <= 1'b1;
                            to_q   <= 1'b0;
                            lock_q <= 1'b0;
                            state  <= RUN;
                        end else if (cnt == CNT_MAX) begin
                            to_q   <= 1'b1;
                            lock_q <= 1'b0;
                            state  <= IDLE;
                        end
                    end
                    RUN: begin
                        if (sq_edge) begin
                            hp_q   <= meas;
                            pv_q   <= 1'b1;
                            lock_q <= (diff <= TOL_LIM);
                        end else if (cnt == CNT_MAX) begin
                            to_q   <= 1'b1;
                            lock_q <= 1'b0;
                            state  <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.half_period  = hp_q;
    assign bus.period_valid = pv_q;
    assign bus.locked       = lock_q;
    assign bus.timeout      = to_q;

endmodule
